// File: rtl/scan_chain_controller.sv
// Scan-chain master: loads one design's slot, latches it, captures its outputs, shifts them back, and generates a slow clock.
// Optional SCAN_SEL_ERR_EN adds a sel_err flag and makes outputs hold on an out-of-range select.
module scan_chain_controller #(
  parameter int unsigned NUM_DESIGNS   = 250,
  parameter int unsigned IO_WIDTH      = 8,
  parameter int unsigned SEL_WIDTH     = 9,
  parameter int unsigned CLK_DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 set_clk_div,
  input  logic [SEL_WIDTH-1:0] active_select,
  input  logic [IO_WIDTH-1:0]  inputs,
  output logic [IO_WIDTH-1:0]  outputs,
  output logic                 ready,
  output logic                 slow_clk,
  output logic                 scan_clk_out,
  output logic                 scan_data_out,
  input  logic                 scan_data_in,
  output logic                 scan_select,
  output logic                 scan_latch_en
`ifdef SCAN_SEL_ERR_EN
  , output logic               sel_err
`endif
);

  localparam int unsigned L  = NUM_DESIGNS * IO_WIDTH;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned IW = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     phase;
  logic [IO_WIDTH-1:0]      in_snap;
  logic [SEL_WIDTH-1:0]     sel_snap;
  logic [IO_WIDTH-1:0]      out_shadow;
  logic [CLK_DIV_WIDTH-1:0] div_reg;
  logic [CLK_DIV_WIDTH-1:0] rcnt;
  logic                     first_bit;

  // Shift count c addresses chain position L-1-c: the first bit shifted travels furthest.
  function automatic int unsigned pos(input logic [CW-1:0] c);
    return (L - 1) - 32'(c);
  endfunction

  function automatic logic in_slot(input int unsigned p, input logic [SEL_WIDTH-1:0] s);
    return (p / IO_WIDTH) == 32'(s);
  endfunction

  function automatic logic drive_bit(input logic [CW-1:0] c, input logic [IO_WIDTH-1:0] d,
                                     input logic [SEL_WIDTH-1:0] s);
    int unsigned p;
    p = pos(c);
    return in_slot(p, s) ? d[IW'(p % IO_WIDTH)] : 1'b0;
  endfunction

  // First bit comes straight from the live inputs since the snapshot loads on the same edge.
  always_comb first_bit = drive_bit('0, inputs, active_select);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      phase         <= 1'b0;
      in_snap       <= '0;
      sel_snap      <= '0;
      out_shadow    <= '0;
      div_reg       <= '0;
      rcnt          <= '0;
      outputs       <= '0;
      ready         <= 1'b0;
      slow_clk      <= 1'b0;
      scan_clk_out  <= 1'b0;
      scan_data_out <= 1'b0;
      scan_select   <= 1'b0;
      scan_latch_en <= 1'b0;
`ifdef SCAN_SEL_ERR_EN
      sel_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (set_clk_div) begin
            div_reg <= inputs[CLK_DIV_WIDTH-1:0];
          end else if (enable) begin
            in_snap       <= inputs;
            sel_snap      <= active_select;
            out_shadow    <= '0;
            cnt           <= '0;
            phase         <= 1'b0;
            scan_clk_out  <= 1'b0;
            scan_data_out <= first_bit;
            state         <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (!phase) begin
            scan_clk_out <= 1'b1;
            phase        <= 1'b1;
          end else begin
            scan_clk_out <= 1'b0;
            phase        <= 1'b0;
            if (cnt == LAST) begin
              scan_data_out <= 1'b0;
              scan_latch_en <= 1'b1;
              state         <= LATCH;
            end else begin
              cnt           <= cnt + 1'b1;
              scan_data_out <= drive_bit(cnt + 1'b1, in_snap, sel_snap);
            end
          end
        end
        LATCH: begin
          scan_latch_en <= 1'b0;
          scan_select   <= 1'b1;
          phase         <= 1'b0;
          state         <= CAPTURE;
        end
        CAPTURE: begin
          if (!phase) begin
            scan_clk_out <= 1'b1;
            phase        <= 1'b1;
          end else begin
            scan_clk_out <= 1'b0;
            scan_select  <= 1'b0;
            phase        <= 1'b0;
            cnt          <= '0;
            state        <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          if (!phase) begin
            // Sampled on the edge that raises scan_clk_out, i.e. before the chain shifts.
            scan_clk_out <= 1'b1;
            phase        <= 1'b1;
            if (in_slot(pos(cnt), sel_snap))
              out_shadow[IW'(pos(cnt) % IO_WIDTH)] <= scan_data_in;
          end else begin
            scan_clk_out <= 1'b0;
            phase        <= 1'b0;
            if (cnt == LAST) begin
              ready <= 1'b1;
              state <= DONE;
`ifdef SCAN_SEL_ERR_EN
              sel_err <= (32'(sel_snap) >= NUM_DESIGNS);
              if (32'(sel_snap) < NUM_DESIGNS) outputs <= out_shadow;
`else
              outputs <= out_shadow;
`endif
              if (rcnt == div_reg) begin
                slow_clk <= ~slow_clk;
                rcnt     <= '0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          ready <= 1'b0;
          if (set_clk_div) begin
            div_reg <= inputs[CLK_DIV_WIDTH-1:0];
            rcnt    <= '0;
          end
          if (enable) begin
            in_snap       <= inputs;
            sel_snap      <= active_select;
            out_shadow    <= '0;
            cnt           <= '0;
            phase         <= 1'b0;
            scan_clk_out  <= 1'b0;
            scan_data_out <= first_bit;
            state         <= SHIFT_IN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller with a 4-design echo chain (each slot returns its latched inputs).
module tb_scan_chain_controller;
  localparam int unsigned ND = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned L  = ND * IW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          set_clk_div = 1'b0;
  logic [2:0]    active_select = '0;
  logic [IW-1:0] inputs = '0;
  logic [IW-1:0] outputs;
  logic          ready, slow_clk, scan_clk_out, scan_data_out, scan_data_in;
  logic          scan_select, scan_latch_en;
`ifdef SCAN_SEL_ERR_EN
  logic          sel_err;
`endif

  int checks = 0;
  int errors = 0;

  scan_chain_controller #(
    .NUM_DESIGNS(ND), .IO_WIDTH(IW), .SEL_WIDTH(3), .CLK_DIV_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .set_clk_div(set_clk_div),
    .active_select(active_select), .inputs(inputs), .outputs(outputs), .ready(ready),
    .slow_clk(slow_clk), .scan_clk_out(scan_clk_out), .scan_data_out(scan_data_out),
    .scan_data_in(scan_data_in), .scan_select(scan_select), .scan_latch_en(scan_latch_en)
`ifdef SCAN_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: position 0 takes scan_data_out, position L-1 drives scan_data_in.
  logic [L-1:0] chain = '0;
  logic [L-1:0] latched = '0;
  assign scan_data_in = chain[L-1];
  always @(posedge scan_clk_out) begin
    if (scan_select) chain <= latched;
    else             chain <= {chain[L-2:0], scan_data_out};
  end
  always @(posedge clk) if (scan_latch_en) latched <= chain;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ready !== 1'b1 && n < max);
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ones, clk_hi, rdy_hi;
    logic [IW-1:0] prev;
    logic exp_slow;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", outputs, 0);
    check("rst_ready", ready, 0);
    check("rst_slow_clk", slow_clk, 0);
    check("rst_scan_clk", scan_clk_out, 0);
    check("rst_scan_sel", scan_select, 0);
    check("rst_latch_en", scan_latch_en, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic refresh of slot 2
    active_select = 3'd2; inputs = 8'hA5; enable = 1'b1;
    wait_ready(300, n);
    check("lat_132", n, 132);
    check("out_a5", outputs, 8'hA5);
    check("slot0_zero", latched[7:0], 0);
    check("slot1_zero", latched[15:8], 0);
    check("slot2_a5", latched[23:16], 8'hA5);
    check("slot3_zero", latched[31:24], 0);
    check("slow_div0_1", slow_clk, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", ready, 0);

    // Mid-refresh input change only affects the next snapshot
    active_select = 3'd0; inputs = 8'h3C; enable = 1'b1;
    repeat (40) @(posedge clk);
    #1 inputs = 8'hFF;
    wait_ready(300, n);
    check("lat_after_40", n, 92);
    check("out_3c", outputs, 8'h3C);
    wait_ready(300, n);
    check("lat_back_to_back", n, 132);
    check("out_ff", outputs, 8'hFF);
    enable = 1'b0;
    prev = outputs;

    // Out-of-range select
    @(posedge clk); #1;
    active_select = 3'd5; inputs = 8'hFF; enable = 1'b1;
    ones = 0; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (scan_data_out === 1'b1) ones++;
    end while (ready !== 1'b1 && n < 300);
    check("oor_ready", ready, 1);
    check("oor_sdo_zero", ones, 0);
`ifdef SCAN_SEL_ERR_EN
    check("oor_out_hold", outputs, prev);
    check("oor_sel_err", sel_err, 1);
`else
    check("oor_out_zero", outputs, 0);
`endif
    check("slow_after_4", slow_clk, 0);
    enable = 1'b0;
    @(posedge clk); #1;

    // Divider N=2: slow_clk toggles at refreshes 3, 6, 9
    set_clk_div = 1'b1; inputs = 8'h02;
    @(posedge clk); #1;
    set_clk_div = 1'b0;
    active_select = 3'd1; inputs = 8'h5A; enable = 1'b1;
    exp_slow = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      wait_ready(300, n);
      if (k % 3 == 0) exp_slow = ~exp_slow;
      check($sformatf("slow_k%0d", k), slow_clk, exp_slow);
    end
    check("out_5a", outputs, 8'h5A);
`ifdef SCAN_SEL_ERR_EN
    check("sel_err_clear", sel_err, 0);
`endif
    enable = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-refresh
    active_select = 3'd3; inputs = 8'h81; enable = 1'b1;
    repeat (70) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_outputs", outputs, 0);
    check("arst_slow", slow_clk, 0);
    check("arst_ready", ready, 0);
    check("arst_scan_clk", scan_clk_out, 0);
    check("arst_sdo", scan_data_out, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_ready(300, n);
    check("post_rst_lat", n, 132);
    check("post_rst_out", outputs, 8'h81);

    // enable dropped 10 clocks into a refresh
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    wait_ready(300, n);
    check("drop_lat", n, 122);
    check("drop_out", outputs, 8'h81);
    clk_hi = 0; rdy_hi = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (scan_clk_out === 1'b1) clk_hi++;
      if (ready === 1'b1) rdy_hi++;
    end
    check("idle_no_scan_clk", clk_hi, 0);
    check("idle_no_ready", rdy_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
